// File: rtl/iob_cpu_bus_bridge.sv
// CPU command bus to IOb bridge. Requests pass through combinationally.
// Responses come back in acceptance order, tracked with a tag FIFO and a read-data FIFO.
module iob_cpu_bus_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter bit          REMAP_EN = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       boot_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_wr_i,
  input  logic [ADDR_W-1:0]          cmd_addr_i,
  input  logic [DATA_W-1:0]          cmd_data_i,
  input  logic [DATA_W/8-1:0]        cmd_mask_i,
  output logic                       rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       rsp_error_o,
  output logic                       iob_avalid_o,
  output logic [ADDR_W-1:0]          iob_addr_o,
  output logic [DATA_W-1:0]          iob_wdata_o,
  output logic [DATA_W/8-1:0]        iob_wstrb_o,
  input  logic                       iob_ready_i,
  input  logic                       iob_rvalid_i,
  input  logic [DATA_W-1:0]          iob_rdata_i,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic                       rvalid_err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Tag FIFO (1 = write); its occupancy is the pending count.
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PtrW-1:0]  tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [CntW-1:0]  pend_q, pend_d;

  // Read-data FIFO plus count of reads still waiting for rvalid.
  logic [DATA_W-1:0] rdf_mem_q [DEPTH];
  logic [PtrW-1:0]   rdf_wp_q, rdf_wp_d, rdf_rp_q, rdf_rp_d;
  logic [CntW-1:0]   rdf_cnt_q, rdf_cnt_d;
  logic [CntW-1:0]   rd_out_q, rd_out_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  logic full, accept, rd_accept, tag_head, retire, rd_retire, rdf_push;

  function automatic logic [CntW-1:0] upd(input logic [CntW-1:0] cnt, input logic inc,
                                          input logic dec);
    logic [CntW-1:0] r;
    r = cnt;
    if (inc && !dec) r = cnt + CntW'(1);
    if (dec && !inc) r = cnt - CntW'(1);
    return r;
  endfunction

  // Request path: full is forced low in reset so flow control sees an empty bridge.
  always_comb begin
    full         = rst_ni & (pend_q == CntW'(DEPTH));
    cmd_ready_o  = iob_ready_i & ~full;
    iob_avalid_o = cmd_valid_i & ~full;
    iob_wdata_o  = cmd_data_i;
    iob_wstrb_o  = cmd_wr_i ? cmd_mask_i : '0;
    iob_addr_o   = cmd_addr_i;
    if (REMAP_EN) iob_addr_o[ADDR_W-1] = ~boot_i;
  end

  logic unused_addr_msb;
  assign unused_addr_msb = cmd_addr_i[ADDR_W-1];

  // Next-state for FIFOs, counters and the registered response.
  always_comb begin
    accept    = cmd_valid_i & cmd_ready_o;
    rd_accept = accept & ~cmd_wr_i;
    tag_head  = tag_q[tag_rp_q];
    retire    = (pend_q != '0) && (tag_head || (rdf_cnt_q != '0));
    rd_retire = retire & ~tag_head;
    rdf_push  = iob_rvalid_i && (rd_out_q != '0);

    tag_d = tag_q;
    if (accept) tag_d[tag_wp_q] = cmd_wr_i;
    tag_wp_d  = accept ? tag_wp_q + PtrW'(1) : tag_wp_q;
    tag_rp_d  = retire ? tag_rp_q + PtrW'(1) : tag_rp_q;
    pend_d    = upd(pend_q, accept, retire);

    rdf_wp_d  = rdf_push ? rdf_wp_q + PtrW'(1) : rdf_wp_q;
    rdf_rp_d  = rd_retire ? rdf_rp_q + PtrW'(1) : rdf_rp_q;
    rdf_cnt_d = upd(rdf_cnt_q, rdf_push, rd_retire);
    rd_out_d  = upd(rd_out_q, rd_accept, rdf_push);

    rsp_valid_d = retire;
    rsp_data_d  = rsp_data_q;
    if (retire) rsp_data_d = tag_head ? '0 : rdf_mem_q[rdf_rp_q];

    err_d = err_q | (iob_rvalid_i & (rd_out_q == '0));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_q       <= '0;
      tag_wp_q    <= '0;
      tag_rp_q    <= '0;
      pend_q      <= '0;
      rdf_wp_q    <= '0;
      rdf_rp_q    <= '0;
      rdf_cnt_q   <= '0;
      rd_out_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      tag_wp_q    <= tag_wp_d;
      tag_rp_q    <= tag_rp_d;
      pend_q      <= pend_d;
      rdf_wp_q    <= rdf_wp_d;
      rdf_rp_q    <= rdf_rp_d;
      rdf_cnt_q   <= rdf_cnt_d;
      rd_out_q    <= rd_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Read-data storage; validity is tracked by the counters, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (rst_ni && rdf_push) rdf_mem_q[rdf_wp_q] <= iob_rdata_i;
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_error_o  = 1'b0;
  assign pending_o    = pend_q;
  assign rvalid_err_o = err_q;

endmodule
